hub75_row_capture: RTL and testbench

- Receive-side model of the HUB75 panel interface; used as loopback and checker for led_display_driver / led_display_driver_phy in benches and on-board.
- Oversamples bclk, rgb_top, rgb_bot, le, oe and addr on the system clock.
- Shifts the serial colour bits into per-row shift registers and transfers a completed row, with its row address, to output registers on each latch pulse.
- Flags rows whose bit count does not equal NUM_COLS.

---
 rtl/hub75_pkg.sv | 21 ++
 rtl/hub75_in_sync.sv | 37 +++
 rtl/hub75_row_capture.sv | 208 ++++++++++++++++++++
 tb/tb_hub75_row_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and defaults for the HUB75 receive-side capture.
//   NUM_COLS_DEF : default pixels per row (bits per latch per colour line)
//   ADDR_W_DEF   : default row address width
//   rgb_t        : one serial bit for each of R (bit 0), G (bit 1), B (bit 2)
//   row_t        : one captured row, indexed [colour][column]
//   cap_state_t  : capture FSM states
package hub75_pkg;

   localparam int NUM_COLS_DEF = 64;
   localparam int ADDR_W_DEF   = 4;

   typedef logic [2:0] rgb_t;
   typedef logic [2:0][NUM_COLS_DEF-1:0] row_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } cap_state_t;

endpackage

// File: rtl/hub75_in_sync.sv
// hub75_in_sync: W-bit two-flop synchroniser with a rise-edge strobe.
//   clk_in     : system clock
//   n_reset_in : synchronous active-low reset (all stages load RST_VAL)
//   d_in       : asynchronous input bus
//   sync_out   : second synchroniser stage
//   rise_out   : one-cycle strobe per bit, second stage high and third stage low
module hub75_in_sync #(
   parameter int   W       = 1,
   parameter logic RST_VAL = 1'b0
) (
   input  logic         clk_in,
   input  logic         n_reset_in,
   input  logic [W-1:0] d_in,
   output logic [W-1:0] sync_out,
   output logic [W-1:0] rise_out
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;
   logic [W-1:0] s3_q;

   always_ff @(posedge clk_in) begin
      if (!n_reset_in) begin
         s1_q <= {W{RST_VAL}};
         s2_q <= {W{RST_VAL}};
         s3_q <= {W{RST_VAL}};
      end else begin
         s1_q <= d_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign sync_out = s2_q;
   assign rise_out = s2_q & ~s3_q;

endmodule

// File: rtl/hub75_row_capture.sv
// hub75_row_capture: receive-side HUB75 model. Oversamples the panel pins on
// clk_in, shifts the serial colour bits into per-row shift registers and
// presents each completed row with its address on every latch pulse.
// Optional feature macro: HUB75_OE_MON_EN adds oe_on_cycles_out, the number
// of clk cycles with synchronised oe low between consecutive latches.
// Ports:
//   clk_in, n_reset_in      : system clock, synchronous active-low reset
//   bclk_in, le_in, oe_in   : HUB75 bit clock, latch enable, output enable (low)
//   rgb_top_in, rgb_bot_in  : serial {B,G,R} for the top and bottom halves
//   addr_in                 : row address
//   row_top_out/row_bot_out : captured rows, [colour][column]
//   row_addr_out            : address sampled at the latch
//   row_valid_out           : one-cycle pulse per presented row
//   bit_count_out           : bclk rises counted for the presented row
//   len_err_out             : sticky, some row had a count other than NUM_COLS
//   busy_out                : high while shifting a row
module hub75_row_capture
   import hub75_pkg::*;
#(
   parameter int NUM_COLS      = NUM_COLS_DEF,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int SYS_CLK_FREQ  = 100_000_000,
   parameter int BCLK_MAX_FREQ = 25_000_000
) (
   input  logic                            clk_in,
   input  logic                            n_reset_in,
   input  logic                            bclk_in,
   input  logic [2:0]                      rgb_top_in,
   input  logic [2:0]                      rgb_bot_in,
   input  logic                            le_in,
   input  logic                            oe_in,
   input  logic [ADDR_W-1:0]               addr_in,
   output logic [2:0][NUM_COLS-1:0]        row_top_out,
   output logic [2:0][NUM_COLS-1:0]        row_bot_out,
   output logic [ADDR_W-1:0]               row_addr_out,
   output logic                            row_valid_out,
   output logic [$clog2(NUM_COLS+2)-1:0]   bit_count_out,
   output logic                            len_err_out,
   output logic                            busy_out
`ifdef HUB75_OE_MON_EN
   ,
   output logic [31:0]                     oe_on_cycles_out
`endif
);

   localparam int CNT_W = $clog2(NUM_COLS + 2);
   localparam int BUS_W = 6 + ADDR_W;

   // Each bclk phase must span at least two system clocks to be seen.
   if (SYS_CLK_FREQ / BCLK_MAX_FREQ < 4) begin : g_freq_check
      $error("hub75_row_capture: SYS_CLK_FREQ must be at least 4x BCLK_MAX_FREQ");
   end

   // ---------------- input synchronisation ----------------
   logic             bclk_sync, bclk_rise;
   logic             le_sync, le_rise;
   logic             oe_sync, oe_rise;
   logic [BUS_W-1:0] bus_sync, bus_rise;

   hub75_in_sync #(.W(1), .RST_VAL(1'b0)) u_sync_bclk (
      .clk_in(clk_in), .n_reset_in(n_reset_in), .d_in(bclk_in),
      .sync_out(bclk_sync), .rise_out(bclk_rise));

   hub75_in_sync #(.W(1), .RST_VAL(1'b0)) u_sync_le (
      .clk_in(clk_in), .n_reset_in(n_reset_in), .d_in(le_in),
      .sync_out(le_sync), .rise_out(le_rise));

   hub75_in_sync #(.W(1), .RST_VAL(1'b1)) u_sync_oe (
      .clk_in(clk_in), .n_reset_in(n_reset_in), .d_in(oe_in),
      .sync_out(oe_sync), .rise_out(oe_rise));

   // Data shares the bclk pipeline depth, so the bit sampled alongside the
   // bclk strobe is the one the driver set up before that rising edge.
   hub75_in_sync #(.W(BUS_W), .RST_VAL(1'b0)) u_sync_bus (
      .clk_in(clk_in), .n_reset_in(n_reset_in),
      .d_in({addr_in, rgb_bot_in, rgb_top_in}),
      .sync_out(bus_sync), .rise_out(bus_rise));

   rgb_t              top_bit, bot_bit;
   logic [ADDR_W-1:0] addr_sync;

   assign top_bit   = bus_sync[2:0];
   assign bot_bit   = bus_sync[5:3];
   assign addr_sync = bus_sync[BUS_W-1:6];

   // Level copies and data-bus strobes are not needed by the capture logic.
   logic unused_sync;
   assign unused_sync = ^{bclk_sync, le_sync, oe_sync, oe_rise, bus_rise};

   // ---------------- capture FSM and shift path ----------------
   cap_state_t                state_q, state_d;
   logic [2:0][NUM_COLS-1:0]  shift_top_q, shift_top_d;
   logic [2:0][NUM_COLS-1:0]  shift_bot_q, shift_bot_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   always_comb begin
      state_d     = state_q;
      shift_top_d = shift_top_q;
      shift_bot_d = shift_bot_q;
      cnt_d       = cnt_q;

      // Shifting happens before the state decision, so a bit arriving with
      // the latch strobe is part of the latched row.
      if (bclk_rise) begin
         for (int c = 0; c < 3; c++) begin
            shift_top_d[c] = {shift_top_q[c][NUM_COLS-2:0], top_bit[c]};
            shift_bot_d[c] = {shift_bot_q[c][NUM_COLS-2:0], bot_bit[c]};
         end
         if (cnt_q != CNT_W'(NUM_COLS + 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (le_rise) begin
               state_d = LATCH;
            end else if (bclk_rise) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (le_rise) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   logic [2:0][NUM_COLS-1:0] row_top_q, row_bot_q;
   logic [ADDR_W-1:0]        row_addr_q;
   logic                     row_valid_q;
   logic [CNT_W-1:0]         bit_count_q;
   logic                     len_err_q;

   always_ff @(posedge clk_in) begin
      if (!n_reset_in) begin
         state_q     <= IDLE;
         shift_top_q <= '0;
         shift_bot_q <= '0;
         cnt_q       <= '0;
         row_top_q   <= '0;
         row_bot_q   <= '0;
         row_addr_q  <= '0;
         row_valid_q <= 1'b0;
         bit_count_q <= '0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_top_q <= shift_top_d;
         shift_bot_q <= shift_bot_d;
         cnt_q       <= cnt_d;
         row_valid_q <= (state_q == LATCH);
         if (state_q == LATCH) begin
            row_top_q   <= shift_top_q;
            row_bot_q   <= shift_bot_q;
            row_addr_q  <= addr_sync;
            bit_count_q <= cnt_q;
            if (cnt_q != CNT_W'(NUM_COLS)) begin
               len_err_q <= 1'b1;
            end
         end
      end
   end

   assign row_top_out   = row_top_q;
   assign row_bot_out   = row_bot_q;
   assign row_addr_out  = row_addr_q;
   assign row_valid_out = row_valid_q;
   assign bit_count_out = bit_count_q;
   assign len_err_out   = len_err_q;
   assign busy_out      = (state_q == SHIFT);

`ifdef HUB75_OE_MON_EN
   // ---------------- oe on-time monitor ----------------
   logic [31:0] oe_cnt_q, oe_cnt_d;
   logic [31:0] oe_on_q;

   always_comb begin
      oe_cnt_d = oe_cnt_q;
      if (state_q == LATCH) begin
         oe_cnt_d = '0;
      end else if (!oe_sync) begin
         oe_cnt_d = oe_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!n_reset_in) begin
         oe_cnt_q <= '0;
         oe_on_q  <= '0;
      end else begin
         oe_cnt_q <= oe_cnt_d;
         if (state_q == LATCH) begin
            oe_on_q <= oe_cnt_q;
         end
      end
   end

   assign oe_on_cycles_out = oe_on_q;
`endif

endmodule

// File: tb/tb_hub75_row_capture.sv
// tb_hub75_row_capture: directed bench for hub75_row_capture. Drives bclk at
// a quarter of the system clock, rgb changing on bclk fall, and checks each
// latched row against hand-computed constants.
module tb_hub75_row_capture;

   localparam int NC = 64;
   localparam int AW = 4;
   localparam int CW = 7;

   localparam logic [63:0] P1T = 64'h5566778899AABBCC;
   localparam logic [63:0] P1B = 64'hFFEEDDCCBBAA9988;
   localparam logic [63:0] P2T = 64'h0123456789ABCDEF;
   localparam logic [63:0] P2B = 64'hFEDCBA9876543210;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 n_reset = 1'b0;
   logic                 bclk_in = 1'b0;
   logic [2:0]           rgb_top_in = '0;
   logic [2:0]           rgb_bot_in = '0;
   logic                 le_in = 1'b0;
   logic                 oe_in = 1'b1;
   logic [AW-1:0]        addr_in = '0;
   logic [2:0][NC-1:0]   row_top_out;
   logic [2:0][NC-1:0]   row_bot_out;
   logic [AW-1:0]        row_addr_out;
   logic                 row_valid_out;
   logic [CW-1:0]        bit_count_out;
   logic                 len_err_out;
   logic                 busy_out;
`ifdef HUB75_OE_MON_EN
   logic [31:0]          oe_on_cycles_out;
`endif

   hub75_row_capture dut (
      .clk_in(clk), .n_reset_in(n_reset), .bclk_in(bclk_in),
      .rgb_top_in(rgb_top_in), .rgb_bot_in(rgb_bot_in), .le_in(le_in),
      .oe_in(oe_in), .addr_in(addr_in), .row_top_out(row_top_out),
      .row_bot_out(row_bot_out), .row_addr_out(row_addr_out),
      .row_valid_out(row_valid_out), .bit_count_out(bit_count_out),
      .len_err_out(len_err_out), .busy_out(busy_out)
`ifdef HUB75_OE_MON_EN
      , .oe_on_cycles_out(oe_on_cycles_out)
`endif
   );

   int checks = 0;
   int passed = 0;
   int valid_total = 0;

   always @(negedge clk) begin
      if (row_valid_out === 1'b1) valid_total++;
   end

   // ---------------- driver tasks ----------------
   // Sends bits t[n-1] down to t[0]; with join_le the final bclk rise is
   // driven together with le and the task returns at that instant.
   task automatic send_row(input int n, input logic [71:0] t, input logic [71:0] b,
                           input bit join_le);
      for (int i = n - 1; i >= 0; i--) begin
         bclk_in    = 1'b0;
         rgb_top_in = {2'b00, t[i]};
         rgb_bot_in = {2'b00, b[i]};
         repeat (2) @(negedge clk);
         bclk_in = 1'b1;
         if (join_le && i == 0) le_in = 1'b1;
         else repeat (2) @(negedge clk);
      end
   endtask

   // Holds le high for two clocks and watches a bounded window for pulses.
   task automatic latch_row(input bit le_up, output int pulses, output int first_at);
      pulses   = 0;
      first_at = -1;
      if (!le_up) le_in = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 1) le_in = 1'b0;
         if (row_valid_out === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = i;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (row_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", row_valid_out); else passed++;
      checks++; if (row_top_out !== '0) $display("FAIL reset_row_top: got %h want 0", row_top_out); else passed++;
      checks++; if (row_bot_out !== '0) $display("FAIL reset_row_bot: got %h want 0", row_bot_out); else passed++;
      checks++; if (row_addr_out !== 4'h0) $display("FAIL reset_addr: got %h want 0", row_addr_out); else passed++;
      checks++; if (bit_count_out !== 7'd0) $display("FAIL reset_count: got %0d want 0", bit_count_out); else passed++;
      checks++; if (len_err_out !== 1'b0) $display("FAIL reset_err: got %b want 0", len_err_out); else passed++;
      checks++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_out); else passed++;
      n_reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_full_row();
      int p, f;
      addr_in = 4'h5;
      send_row(64, {8'h00, P1T}, {8'h00, P1B}, 1'b0);
      checks++; if (busy_out !== 1'b1) $display("FAIL full_busy: got %b want 1", busy_out); else passed++;
      latch_row(1'b0, p, f);
      checks++; if (p != 1) $display("FAIL full_pulses: got %0d want 1", p); else passed++;
      checks++; if (f != 3) $display("FAIL full_latency: got %0d want 3", f); else passed++;
      checks++; if (row_top_out[0] !== P1T) $display("FAIL full_top_r: got %h want %h", row_top_out[0], P1T); else passed++;
      checks++; if (row_top_out[1] !== 64'h0 || row_top_out[2] !== 64'h0) $display("FAIL full_top_gb: got %h %h want 0", row_top_out[1], row_top_out[2]); else passed++;
      checks++; if (row_bot_out[0] !== P1B) $display("FAIL full_bot_r: got %h want %h", row_bot_out[0], P1B); else passed++;
      checks++; if (row_addr_out !== 4'h5) $display("FAIL full_addr: got %h want 5", row_addr_out); else passed++;
      checks++; if (bit_count_out !== 7'd64) $display("FAIL full_count: got %0d want 64", bit_count_out); else passed++;
      checks++; if (len_err_out !== 1'b0) $display("FAIL full_err: got %b want 0", len_err_out); else passed++;
      checks++; if (busy_out !== 1'b0) $display("FAIL full_busy_after: got %b want 0", busy_out); else passed++;
   endtask

   task automatic test_simultaneous();
      int p, f;
      addr_in = 4'hC;
      send_row(64, {8'h00, P2T}, {8'h00, P2B}, 1'b1);
      latch_row(1'b1, p, f);
      checks++; if (p != 1) $display("FAIL simul_pulses: got %0d want 1", p); else passed++;
      checks++; if (bit_count_out !== 7'd64) $display("FAIL simul_count: got %0d want 64", bit_count_out); else passed++;
      checks++; if (len_err_out !== 1'b0) $display("FAIL simul_err: got %b want 0", len_err_out); else passed++;
      checks++; if (row_top_out[0] !== P2T) $display("FAIL simul_top: got %h want %h", row_top_out[0], P2T); else passed++;
      checks++; if (row_bot_out[0] !== P2B) $display("FAIL simul_bot: got %h want %h", row_bot_out[0], P2B); else passed++;
      checks++; if (row_addr_out !== 4'hC) $display("FAIL simul_addr: got %h want c", row_addr_out); else passed++;
   endtask

   task automatic test_short_row();
      int p, f;
      addr_in = 4'h3;
      send_row(63, {9'h000, P1T[62:0]}, {9'h000, P1B[62:0]}, 1'b0);
      latch_row(1'b0, p, f);
      checks++; if (p != 1) $display("FAIL short_pulses: got %0d want 1", p); else passed++;
      checks++; if (bit_count_out !== 7'd63) $display("FAIL short_count: got %0d want 63", bit_count_out); else passed++;
      checks++; if (len_err_out !== 1'b1) $display("FAIL short_err: got %b want 1", len_err_out); else passed++;
      // Oldest bit of the previous row (P2 bit 0) survives at column 63.
      checks++; if (row_top_out[0] !== 64'hD566778899AABBCC) $display("FAIL short_top: got %h want d566778899aabbcc", row_top_out[0]); else passed++;
      checks++; if (row_bot_out[0] !== 64'h7FEEDDCCBBAA9988) $display("FAIL short_bot: got %h want 7feeddccbbaa9988", row_bot_out[0]); else passed++;
      checks++; if (row_addr_out !== 4'h3) $display("FAIL short_addr: got %h want 3", row_addr_out); else passed++;
      addr_in = 4'hA;
      send_row(64, {8'h00, P1T}, {8'h00, P1B}, 1'b0);
      latch_row(1'b0, p, f);
      checks++; if (bit_count_out !== 7'd64) $display("FAIL sticky_count: got %0d want 64", bit_count_out); else passed++;
      checks++; if (len_err_out !== 1'b1) $display("FAIL sticky_err: got %b want 1", len_err_out); else passed++;
      checks++; if (row_top_out[0] !== P1T) $display("FAIL sticky_top: got %h want %h", row_top_out[0], P1T); else passed++;
      checks++; if (row_addr_out !== 4'hA) $display("FAIL sticky_addr: got %h want a", row_addr_out); else passed++;
   endtask

   task automatic test_long_row();
      int p, f;
      addr_in = 4'h6;
      send_row(66, {6'h00, 2'b11, P2T}, {6'h00, 2'b10, P2B}, 1'b0);
      latch_row(1'b0, p, f);
      checks++; if (p != 1) $display("FAIL long_pulses: got %0d want 1", p); else passed++;
      checks++; if (bit_count_out !== 7'd65) $display("FAIL long_count: got %0d want 65", bit_count_out); else passed++;
      checks++; if (len_err_out !== 1'b1) $display("FAIL long_err: got %b want 1", len_err_out); else passed++;
      checks++; if (row_top_out[0] !== P2T) $display("FAIL long_top: got %h want %h", row_top_out[0], P2T); else passed++;
      checks++; if (row_bot_out[0] !== P2B) $display("FAIL long_bot: got %h want %h", row_bot_out[0], P2B); else passed++;
   endtask

   task automatic test_reset_mid_row();
      int p, f, v0;
      addr_in = 4'h7;
      v0 = valid_total;
      send_row(30, {8'h00, P1T}, {8'h00, P1B}, 1'b0);
      n_reset = 1'b0;
      bclk_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (row_top_out !== '0) $display("FAIL midrst_top: got %h want 0", row_top_out); else passed++;
      checks++; if (len_err_out !== 1'b0) $display("FAIL midrst_err: got %b want 0", len_err_out); else passed++;
      checks++; if (bit_count_out !== 7'd0) $display("FAIL midrst_count: got %0d want 0", bit_count_out); else passed++;
      n_reset = 1'b1;
      send_row(64, {8'h00, P2T}, {8'h00, P2B}, 1'b0);
      checks++; if (valid_total != v0) $display("FAIL midrst_no_pulse: got %0d pulses want 0", valid_total - v0); else passed++;
      latch_row(1'b0, p, f);
      checks++; if (p != 1) $display("FAIL midrst_pulses: got %0d want 1", p); else passed++;
      checks++; if (row_top_out[0] !== P2T) $display("FAIL midrst_top2: got %h want %h", row_top_out[0], P2T); else passed++;
      checks++; if (row_bot_out[0] !== P2B) $display("FAIL midrst_bot2: got %h want %h", row_bot_out[0], P2B); else passed++;
      checks++; if (bit_count_out !== 7'd64) $display("FAIL midrst_count2: got %0d want 64", bit_count_out); else passed++;
      checks++; if (len_err_out !== 1'b0) $display("FAIL midrst_err2: got %b want 0", len_err_out); else passed++;
      checks++; if (row_addr_out !== 4'h7) $display("FAIL midrst_addr: got %h want 7", row_addr_out); else passed++;
   endtask

`ifdef HUB75_OE_MON_EN
   task automatic test_oe_monitor();
      int p, f;
      oe_in = 1'b0;
      repeat (500) @(negedge clk);
      oe_in = 1'b1;
      addr_in = 4'h1;
      send_row(64, {8'h00, P1T}, {8'h00, P1B}, 1'b0);
      latch_row(1'b0, p, f);
      checks++; if (oe_on_cycles_out !== 32'd500) $display("FAIL oe_on_cycles: got %0d want 500", oe_on_cycles_out); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_full_row();
      test_simultaneous();
      test_short_row();
      test_long_row();
      test_reset_mid_row();
`ifdef HUB75_OE_MON_EN
      test_oe_monitor();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
